alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 22 ++
 rtl/alu_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two ALU requesters plus one response channel, grouped for the arbiter.
interface alu_arbiter_if;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [4:0]  req0_op_i, req1_op_i;
  logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_id_o;
  logic [31:0] rsp_result_o;
  logic        rsp_flag_o, rsp_illegal_o;
  modport master (
    output req0_valid_i, req1_valid_i, req0_op_i, req1_op_i,
    output req0_a_i, req0_b_i, req1_a_i, req1_b_i, rsp_ready_i,
    input  req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o,
    input  rsp_result_o, rsp_flag_o, rsp_illegal_o
  );
  modport slave (
    input  req0_valid_i, req1_valid_i, req0_op_i, req1_op_i,
    input  req0_a_i, req0_b_i, req1_a_i, req1_b_i, rsp_ready_i,
    output req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o,
    output rsp_result_o, rsp_flag_o, rsp_illegal_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one riscV_alu between two requesters,
// one operation in flight (IDLE -> EXEC -> RESP).
module riscV_alu (
  input  logic [5:0]  operator_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  output logic [31:0] result_o,
  output logic        comparison_result_o
);
  logic eq, lts, ltu;
  assign eq  = operand_a_i == operand_b_i;
  assign lts = $signed(operand_a_i) < $signed(operand_b_i);
  assign ltu = operand_a_i < operand_b_i;
  // Low bits follow RISC-V funct3; bit 3 selects SUB/SRA; 0b011xxx are branch compares.
  always_comb begin
    result_o = '0;
    comparison_result_o = 1'b0;
    case (operator_i)
      6'b000000: result_o = operand_a_i + operand_b_i;
      6'b001000: result_o = operand_a_i - operand_b_i;
      6'b000001: result_o = operand_a_i << operand_b_i[4:0];
      6'b000010: result_o = {31'd0, lts};
      6'b000011: result_o = {31'd0, ltu};
      6'b000100: result_o = operand_a_i ^ operand_b_i;
      6'b000101: result_o = operand_a_i >> operand_b_i[4:0];
      6'b001101: result_o = $unsigned($signed(operand_a_i) >>> operand_b_i[4:0]);
      6'b000110: result_o = operand_a_i | operand_b_i;
      6'b000111: result_o = operand_a_i & operand_b_i;
      6'b011000: comparison_result_o = eq;
      6'b011001: comparison_result_o = !eq;
      6'b011100: comparison_result_o = lts;
      6'b011101: comparison_result_o = !lts;
      6'b011110: comparison_result_o = ltu;
      6'b011111: comparison_result_o = !ltu;
      default: ;
    endcase
  end
endmodule

module alu_arbiter (
  input logic          clk_i,
  input logic          rst_n_i,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  // One bit per 5-bit operator code; set where the code is a legal ALU op.
  localparam logic [31:0] LEGAL = 32'hF300_21FF;
  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d, id_q, id_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_flag_q, rsp_flag_d, rsp_illegal_q, rsp_illegal_d;
  logic        gnt0, gnt1, legal, alu_flag;
  logic [31:0] alu_result;
  assign gnt0  = state_q == IDLE && bus.req0_valid_i && (!bus.req1_valid_i || !ptr_q);
  assign gnt1  = state_q == IDLE && bus.req1_valid_i && (!bus.req0_valid_i || ptr_q);
  assign legal = LEGAL[op_q];
  riscV_alu u_alu (
    .operator_i          ({1'b0, op_q}),
    .operand_a_i         (a_q),
    .operand_b_i         (b_q),
    .result_o            (alu_result),
    .comparison_result_o (alu_flag)
  );
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_result_d  = rsp_result_q;
    rsp_flag_d    = rsp_flag_q;
    rsp_illegal_d = rsp_illegal_q;
    if (gnt0 || gnt1) begin
      state_d = EXEC;
      ptr_d   = gnt0;
      id_d    = gnt1;
      op_d    = gnt1 ? bus.req1_op_i : bus.req0_op_i;
      a_d     = gnt1 ? bus.req1_a_i : bus.req0_a_i;
      b_d     = gnt1 ? bus.req1_b_i : bus.req0_b_i;
    end
    if (state_q == EXEC) begin
      state_d       = RESP;
      rsp_valid_d   = 1'b1;
      rsp_id_d      = id_q;
      rsp_result_d  = legal ? alu_result : '0;
      rsp_flag_d    = legal && alu_flag;
      rsp_illegal_d = !legal;
    end
    if (state_q == RESP && bus.rsp_ready_i) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      ptr_q         <= 1'b0;
      id_q          <= 1'b0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_flag_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flag_q    <= rsp_flag_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end
  assign bus.req0_ready_o  = gnt0;
  assign bus.req1_ready_o  = gnt1;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_id_o      = rsp_id_q;
  assign bus.rsp_result_o  = rsp_result_q;
  assign bus.rsp_flag_o    = rsp_flag_q;
  assign bus.rsp_illegal_o = rsp_illegal_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors with hand-computed results for alu_arbiter.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  alu_arbiter_if bus();
  alu_arbiter dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_grant(input string tag, input logic exp_id);
    int n = 0;
    #1;
    while (!(bus.req0_ready_o || bus.req1_ready_o) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, 0);
    chk({tag, "_r0"}, {31'd0, bus.req0_ready_o}, {31'd0, !exp_id});
    chk({tag, "_r1"}, {31'd0, bus.req1_ready_o}, {31'd0, exp_id});
    @(posedge clk);
  endtask

  task automatic expect_rsp(input string tag, input logic id, input logic [31:0] res,
                            input logic flag, input logic ill, input int hold);
    @(negedge clk);
    chk({tag, "_exec_v"}, {31'd0, bus.rsp_valid_o}, 0);
    chk({tag, "_exec_rdy"}, {31'd0, bus.req0_ready_o | bus.req1_ready_o}, 0);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      chk({tag, "_v"}, {31'd0, bus.rsp_valid_o}, 1);
      chk({tag, "_id"}, {31'd0, bus.rsp_id_o}, {31'd0, id});
      chk({tag, "_res"}, bus.rsp_result_o, res);
      chk({tag, "_flag"}, {31'd0, bus.rsp_flag_o}, {31'd0, flag});
      chk({tag, "_ill"}, {31'd0, bus.rsp_illegal_o}, {31'd0, ill});
    end
    bus.rsp_ready_i = 1'b1;
    #1 chk({tag, "_no_regrant"}, {31'd0, bus.req0_ready_o | bus.req1_ready_o}, 0);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    chk({tag, "_drop"}, {31'd0, bus.rsp_valid_o}, 0);
  endtask

  task automatic single(input string tag, input logic r, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                        input logic flag, input logic ill, input int hold);
    if (r) begin
      bus.req1_valid_i = 1'b1; bus.req1_op_i = op; bus.req1_a_i = a; bus.req1_b_i = b;
    end else begin
      bus.req0_valid_i = 1'b1; bus.req0_op_i = op; bus.req0_a_i = a; bus.req0_b_i = b;
    end
    wait_grant(tag, r);
    #1;
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    expect_rsp(tag, r, res, flag, ill, hold);
  endtask

  initial begin
    logic exp_id;
    rst_n = 1'b0;
    bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
    bus.req0_op_i = '0; bus.req1_op_i = '0;
    bus.req0_a_i = '0; bus.req0_b_i = '0; bus.req1_a_i = '0; bus.req1_b_i = '0;
    bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.rsp_valid_o}, 0);
    chk("rst_id", {31'd0, bus.rsp_id_o}, 0);
    chk("rst_res", bus.rsp_result_o, 0);
    chk("rst_flag", {31'd0, bus.rsp_flag_o}, 0);
    chk("rst_ill", {31'd0, bus.rsp_illegal_o}, 0);
    rst_n = 1'b1;
    single("add", 1'b0, 5'b00000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 0);
    single("geu", 1'b1, 5'b11111, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 5);
    single("xor", 1'b1, 5'b00100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1'b0, 0);
    single("ill", 1'b0, 5'b01001, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 0);
    single("sra", 1'b0, 5'b01101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 0);
    // Reset in EXEC while the previous SRA result is still on the outputs.
    bus.req0_valid_i = 1'b1; bus.req0_op_i = 5'b00000; bus.req0_a_i = 32'd1; bus.req0_b_i = 32'd2;
    wait_grant("rexec", 1'b0);
    #1 bus.req0_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rexec_v", {31'd0, bus.rsp_valid_o}, 0);
    chk("rexec_res", bus.rsp_result_o, 0);
    chk("rexec_ill", {31'd0, bus.rsp_illegal_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rexec_quiet", {31'd0, bus.rsp_valid_o}, 0);
    end
    // Both valid continuously from reset: grants must alternate starting with req0.
    bus.req0_valid_i = 1'b1; bus.req0_op_i = 5'b01000; bus.req0_a_i = 32'd10; bus.req0_b_i = 32'd3;
    bus.req1_valid_i = 1'b1; bus.req1_op_i = 5'b00010; bus.req1_a_i = 32'hFFFF_FFFF; bus.req1_b_i = 32'd1;
    for (int k = 0; k < 6; k++) begin
      exp_id = k[0];
      wait_grant("rr", exp_id);
      expect_rsp("rr", exp_id, exp_id ? 32'd1 : 32'd7, 1'b0, 1'b0, 0);
    end
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
